// File: rtl/ram_step_tester_pkg.sv
// Shared definitions for the step-paced RAM tester: FSM states and the test pattern.
package ram_step_tester_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WRITE    = 3'd1,
        ST_READ_REQ = 3'd2,
        ST_READ_CHK = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    // Expected word at an address; callers truncate to their data width.
    function automatic logic [31:0] pattern_word(input logic [31:0] addr,
                                                 input logic [31:0] seed);
        return addr ^ seed;
    endfunction

endpackage

// File: rtl/ram_step_tester_spram.sv
// Single-port synchronous RAM with registered read (1-cycle latency); array is not reset.
module spram #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/ram_step_tester.sv
// Step-paced RAM tester: writes a seeded pattern to every word, reads back and counts mismatches.
module ram_step_tester
    import ram_step_tester_pkg::*;
#(
    parameter int unsigned       ADDR_W = 4,
    parameter int unsigned       DATA_W = 8,
    parameter logic [DATA_W-1:0] SEED   = 'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step,
    input  logic              start,
    input  logic              inject,
    output logic [ADDR_W-1:0] led_addr,
    output logic [DATA_W-1:0] led_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   err_count
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] pattern;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              we;

    always_comb begin
        pattern = DATA_W'(pattern_word(32'(addr), 32'(SEED)));
        wdata   = pattern ^ {{(DATA_W-1){1'b0}}, inject};
        we      = (state == ST_WRITE) && step;
    end

    // The RAM reads addr every cycle; addr is held from READ_REQ into READ_CHK.
    spram #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ram (
        .clk  (clk),
        .we   (we),
        .addr (addr),
        .wdata(wdata),
        .rdata(rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            addr      <= '0;
            led_addr  <= '0;
            led_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_count <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        addr      <= '0;
                        error     <= 1'b0;
                        err_count <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        state     <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (step) begin
                        led_addr <= addr;
                        led_data <= wdata;
                        if (addr == ADDR_MAX) begin
                            addr  <= '0;
                            state <= ST_READ_REQ;
                        end else begin
                            addr <= addr + 1'b1;
                        end
                    end
                end
                ST_READ_REQ: begin
                    if (step)
                        state <= ST_READ_CHK;
                end
                ST_READ_CHK: begin
                    led_addr <= addr;
                    led_data <= rdata;
                    if (rdata != pattern) begin
                        error     <= 1'b1;
                        err_count <= err_count + 1'b1;
                    end
                    if (addr == ADDR_MAX) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        addr  <= addr + 1'b1;
                        state <= ST_READ_REQ;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_step_tester.sv
// Bench for ram_step_tester (4-word RAM): table of passes plus reset/start corner sequences.
module tb_ram_step_tester;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       step = 1'b0;
    logic       start = 1'b0;
    logic       inject = 1'b0;
    logic [1:0] led_addr;
    logic [7:0] led_data;
    logic       busy;
    logic       done;
    logic       error;
    logic [2:0] err_count;

    int total = 0;
    int bad = 0;

    logic [9:0] expq[$];
    logic [9:0] prev = '0;
    logic       mon_en = 1'b0;

    typedef struct {
        logic [3:0] mask;
        int         start_at;
        logic       exp_error;
        logic [2:0] exp_cnt;
    } pass_t;

    pass_t passes[5];

    ram_step_tester #(
        .ADDR_W(2),
        .DATA_W(8),
        .SEED  (8'hA5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .step     (step),
        .start    (start),
        .inject   (inject),
        .led_addr (led_addr),
        .led_data (led_data),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input int unsigned a);
        return 8'(a) ^ 8'hA5;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endfunction

    // Every change on the LED pair must match the next expected {addr,data}.
    always @(negedge clk) begin
        if (mon_en && ({led_addr, led_data} !== prev)) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL led_unexpected got=%h want=none", {led_addr, led_data});
            end else begin
                chk("led", 32'({led_addr, led_data}), 32'(expq.pop_front()));
            end
            prev = {led_addr, led_data};
        end
    end

    task automatic do_step();
        @(negedge clk) step = 1'b1;
        @(posedge clk);
        #1 step = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_steps(input logic [3:0] mask, input int start_at);
        for (int i = 0; i < 4; i++) begin
            if (i == start_at)
                pulse_start();
            inject = mask[i];
            expq.push_back({2'(i), pat(i) ^ {7'b0, mask[i]}});
            do_step();
        end
        inject = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expq.push_back({2'(i), pat(i) ^ {7'b0, mask[i]}});
            do_step();
        end
    endtask

    task automatic check_end(input logic exp_error, input logic [2:0] exp_cnt);
        int n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("done", 32'(done), 32'd1);
        chk("busy_end", 32'(busy), 32'd0);
        chk("error", 32'(error), 32'(exp_error));
        chk("err_count", 32'(err_count), 32'(exp_cnt));
        chk("queue_empty", 32'(expq.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        passes[0] = '{4'b0000, -1, 1'b0, 3'd0};
        passes[1] = '{4'b1010, -1, 1'b1, 3'd2};
        passes[2] = '{4'b1111,  1, 1'b1, 3'd4};
        passes[3] = '{4'b0001, -1, 1'b1, 3'd1};
        passes[4] = '{4'b0000,  2, 1'b0, 3'd0};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_led_addr", 32'(led_addr), 32'd0);
        chk("rst_led_data", 32'(led_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        mon_en = 1'b1;

        // Steps without start must leave the tester idle.
        repeat (4) do_step();
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_led", 32'({led_addr, led_data}), 32'd0);

        for (int p = 0; p < 5; p++) begin
            pulse_start();
            @(negedge clk);
            chk("start_busy", 32'(busy), 32'd1);
            chk("start_done", 32'(done), 32'd0);
            chk("start_error", 32'(error), 32'd0);
            chk("start_err_count", 32'(err_count), 32'd0);
            run_steps(passes[p].mask, passes[p].start_at);
            check_end(passes[p].exp_error, passes[p].exp_cnt);
        end

        // Reset after 5 steps: 4 writes and the first readback.
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            expq.push_back({2'(i), pat(i)});
            do_step();
        end
        expq.push_back({2'd0, pat(0)});
        do_step();
        expq.push_back(10'd0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_led", 32'({led_addr, led_data}), 32'd0);

        // start and step together: the step must not write.
        @(negedge clk);
        start = 1'b1;
        step = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        step = 1'b0;
        repeat (2) @(negedge clk);
        chk("samecyc_busy", 32'(busy), 32'd1);
        chk("samecyc_led", 32'({led_addr, led_data}), 32'd0);
        run_steps(4'b0000, -1);
        check_end(1'b0, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
